// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: serial-to-parallel framing around an 8-point parallel FFT/IFFT core.
// Define FFT8_FRAME_CTRL_FRAMECNT_EN to add the frame_cnt output.
module fft8_frame_ctrl #(
   parameter int LAT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [15:0]  in_re,
   input  logic [15:0]  in_im,
   input  logic         in_mode,
   output logic [127:0] fft_xr,
   output logic [127:0] fft_xi,
   output logic         fft_mode,
   input  logic [127:0] fft_yr,
   input  logic [127:0] fft_yi,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [15:0]  out_re,
   output logic [15:0]  out_im,
   output logic [2:0]   out_idx,
   output logic         out_last,
   output logic         busy
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
   ,
   output logic [7:0]   frame_cnt
`endif
);
   localparam int CW = LAT > 0 ? $clog2(LAT + 1) : 1;
   typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;
   state_t state;
   logic [2:0] idx;
   logic [CW-1:0] lat_cnt;
   logic [127:0] xr_q, xi_q, yr_q, yi_q;
   // in_ready is gated by reset so it is low while reset is held and high right after release
   assign in_ready = (state == FILL) && !reset;
   assign out_valid = state == DRAIN;
   assign busy = state != FILL;
   assign out_idx = idx;
   assign out_last = out_valid && idx == 3'd7;
   assign out_re = yr_q[{idx, 4'b0} +: 16];
   assign out_im = yi_q[{idx, 4'b0} +: 16];
   assign fft_xr = xr_q;
   assign fft_xi = xi_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= FILL;
         idx <= '0;
         lat_cnt <= '0;
         xr_q <= '0;
         xi_q <= '0;
         yr_q <= '0;
         yi_q <= '0;
         fft_mode <= 1'b0;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
         frame_cnt <= '0;
`endif
      end else begin
         case (state)
            FILL:
               if (in_valid) begin
                  xr_q[{idx, 4'b0} +: 16] <= in_re;
                  xi_q[{idx, 4'b0} +: 16] <= in_im;
                  if (idx == 3'd0) fft_mode <= in_mode;
                  idx <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= WAIT;
                     lat_cnt <= '0;
                  end
               end
            // core outputs are stable after LAT cycles; capture on the last WAIT edge
            WAIT:
               if (lat_cnt == CW'(LAT)) begin
                  yr_q <= fft_yr;
                  yi_q <= fft_yi;
                  state <= DRAIN;
               end else lat_cnt <= lat_cnt + 1'b1;
            DRAIN:
               if (out_ready) begin
                  idx <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= FILL;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
                     frame_cnt <= frame_cnt + 8'd1;
`endif
                  end
               end
            default: state <= FILL;
         endcase
      end
endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: directed checks of fft8_frame_ctrl against a stand-in core.
module tb_fft8_frame_ctrl;
   localparam int LAT = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
   logic [15:0] in_re = '0, in_im = '0;
   logic in_ready, fft_mode, out_valid, out_last, busy;
   logic [127:0] fft_xr, fft_xi, fft_yr, fft_yi;
   logic [15:0] out_re, out_im;
   logic [2:0] out_idx;
   int total = 0, bad = 0, fc = 0;
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
   logic [7:0] frame_cnt;
`endif
   always #5 clk = ~clk;
   fft8_frame_ctrl #(.LAT(LAT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .in_mode(in_mode),
      .fft_xr(fft_xr), .fft_xi(fft_xi), .fft_mode(fft_mode),
      .fft_yr(fft_yr), .fft_yi(fft_yi),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );
   // stand-in core: every real bin = (sum of real inputs) >>> (3 FFT / 6 IFFT), imag passed by bin, LAT-cycle pipeline
   logic [255:0] pipe [LAT];
   logic [255:0] core_in;
   int sum;
   initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
   always_comb begin
      sum = 0;
      for (int k = 0; k < 8; k++) sum = sum + int'(signed'(fft_xr[16*k +: 16]));
      sum = fft_mode ? (sum >>> 6) : (sum >>> 3);
      core_in = {{8{sum[15:0]}}, fft_xi};
   end
   always @(posedge clk) begin
      pipe[0] <= core_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign fft_yr = pipe[LAT-1][255:128];
   assign fft_yi = pipe[LAT-1][127:0];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic mode, input logic [15:0] re0, input logic [15:0] re_rest,
                            input logic [15:0] im_step, input bit gaps, input bit stall,
                            input logic [15:0] exp_re);
      logic [127:0] exp_xr, exp_xi;
      logic [15:0] exp_im;
      int n, bc;
      for (int k = 0; k < 8; k++) begin
         if (gaps && k[0]) begin
            in_valid = 1'b0;
            in_re = 16'h5a5a;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_re = (k == 0) ? re0 : re_rest;
         in_im = 16'(k) * im_step;
         in_mode = (k == 0) ? mode : ~mode;
         exp_xr[16*k +: 16] = in_re;
         exp_xi[16*k +: 16] = in_im;
         @(negedge clk);
      end
      in_valid = gaps;
      in_re = 16'h7fff;
      in_im = 16'h7fff;
      in_mode = ~mode;
      chk("fft_mode", {127'd0, fft_mode}, {127'd0, mode});
      chk("fft_xr", fft_xr, exp_xr);
      chk("fft_xi", fft_xi, exp_xi);
      n = 0;
      bc = 0;
      while (!out_valid && n < 20) begin
         chk("wait_in_ready", {127'd0, in_ready}, 128'd0);
         bc += int'(busy);
         @(negedge clk);
         n++;
      end
      chk("wait_len", 128'(n), 128'(LAT + 1));
      for (int k = 0; k < 8; k++) begin
         exp_im = 16'(k) * im_step;
         if (stall && k == 2) begin
            out_ready = 1'b0;
            repeat (3) begin
               chk("stall_idx", {125'd0, out_idx}, 128'd2);
               chk("stall_re", {112'd0, out_re}, {112'd0, exp_re});
               chk("stall_im", {112'd0, out_im}, {112'd0, exp_im});
               chk("stall_last", {127'd0, out_last}, 128'd0);
               bc += int'(busy);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
         chk("out_valid", {127'd0, out_valid}, 128'd1);
         chk("out_idx", {125'd0, out_idx}, 128'(k));
         chk("out_re", {112'd0, out_re}, {112'd0, exp_re});
         chk("out_im", {112'd0, out_im}, {112'd0, exp_im});
         chk("out_last", {127'd0, out_last}, {127'd0, k == 7});
         chk("drain_in_ready", {127'd0, in_ready}, 128'd0);
         bc += int'(busy);
         @(negedge clk);
      end
      in_valid = 1'b0;
      fc++;
      chk("post_in_ready", {127'd0, in_ready}, 128'd1);
      chk("post_busy", {127'd0, busy}, 128'd0);
      chk("post_out_valid", {127'd0, out_valid}, 128'd0);
      chk("post_xr_held", fft_xr, exp_xr);
      if (!stall) chk("busy_cycles", 128'(bc), 128'(LAT + 1 + 8));
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
      chk("frame_cnt", {120'd0, frame_cnt}, 128'(fc[7:0]));
`endif
   endtask

   initial begin
      @(negedge clk);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_out_last", {127'd0, out_last}, 128'd0);
      chk("rst_out", {109'd0, out_idx, out_re}, 128'd0);
      chk("rst_xr", fft_xr, 128'd0);
      chk("rst_mode", {127'd0, fft_mode}, 128'd0);
      reset = 1'b0;
      #1 chk("rel_in_ready", {127'd0, in_ready}, 128'd1);
      @(negedge clk);
      run_frame(1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0100);
      run_frame(1'b1, 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0020);
      run_frame(1'b0, 16'h0010, 16'h0010, 16'h0111, 1'b1, 1'b1, 16'h0010);
      run_frame(1'b0, 16'hfff0, 16'hfff0, 16'h2001, 1'b0, 1'b0, 16'hfff0);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_re = 16'h1234 + 16'(k);
         in_im = 16'h4321;
         in_mode = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      reset = 1'b1;
      fc = 0;
      #1;
      chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk("mid_rst_xr", fft_xr, 128'd0);
      chk("mid_rst_mode", {127'd0, fft_mode}, 128'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("mid_rel_in_ready", {127'd0, in_ready}, 128'd1);
      @(negedge clk);
      run_frame(1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0100);
`ifdef FFT8_FRAME_CTRL_FRAMECNT_EN
      repeat (255) run_frame(1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0100);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
